// File: rtl/hdmi_data_island_pkg.sv
// Shared constants and helpers for the HDMI data island packet path.
// The BCH step is the single-bit LFSR update shared by the encoder and decoder.
package hdmi_data_island_pkg;

    localparam logic [7:0] BCH_POLY            = 8'h83;
    localparam int         PACKET_CLOCKS       = 32;
    localparam int         HEADER_DATA_BITS    = 24;
    localparam int         SUBPACKET_DATA_BITS = 56;
    localparam int         PARITY_BITS         = 8;

    localparam logic [0:0] STATE_IDLE      = 1'b0;
    localparam logic [0:0] STATE_RECEIVING = 1'b1;

    typedef logic [SUBPACKET_DATA_BITS-1:0] subpacket_t;

    function automatic logic [PARITY_BITS-1:0] bch_step(input logic [PARITY_BITS-1:0] p,
                                                        input logic d);
        logic f;
        f = d ^ p[0];
        return {1'b0, p[PARITY_BITS-1:1]} ^ (f ? BCH_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/bch_parity_accumulator.sv
// Running BCH parity over a bit stream, BITS_PER_CLOCK bits per enabled clock, data[0] first.
// A clear on an enabled clock restarts from zero and still consumes that clock's bits.
module bch_parity_accumulator
    import hdmi_data_island_pkg::*;
#(
    parameter int BITS_PER_CLOCK = 1
) (
    input  logic                      clock,
    input  logic                      nReset,
    input  logic                      clear,
    input  logic                      enable,
    input  logic [BITS_PER_CLOCK-1:0] data,
    output logic [PARITY_BITS-1:0]    parity
);

    logic [PARITY_BITS-1:0] next_parity;

    always_comb begin
        next_parity = clear ? '0 : parity;
        for (int b = 0; b < BITS_PER_CLOCK; b++) begin
            next_parity = bch_step(next_parity, data[b]);
        end
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            parity <= '0;
        end else if (enable) begin
            parity <= next_parity;
        end else if (clear) begin
            parity <= '0;
        end
    end

endmodule

// File: rtl/data_island_packet_deserializer.sv
// Reassembles one HDMI data island packet (header + four subpackets) from TERC4 nibbles
// over 32 clocks and flags BCH parity mismatches per block.
module data_island_packet_deserializer
    import hdmi_data_island_pkg::*;
(
    input  logic        clock,
    input  logic        nReset,
    input  logic        dataIslandActive,
    input  logic [3:0]  terc4channel0,
    input  logic [3:0]  terc4channel1,
    input  logic [3:0]  terc4channel2,
    output logic [23:0] header,
    output logic [55:0] subpacket0,
    output logic [55:0] subpacket1,
    output logic [55:0] subpacket2,
    output logic [55:0] subpacket3,
    output logic        packetValid,
    output logic [4:0]  eccError,
    output logic        packetAborted,
    output logic        hsync,
    output logic        vsync
);

    logic [0:0]       state;
    logic [4:0]       count;
    logic [23:0]      hdr_data;
    subpacket_t [3:0] sp_data;
    logic [6:0]       hdr_par_rx;
    logic [3:0][5:0]  sp_par_rx;
    logic [7:0]       hdr_par_calc;
    logic [3:0][7:0]  sp_par_calc;

    logic       start, receiving, capture, complete, abort, hdr_en, sp_en;
    logic [4:0] bit_idx;

    // A start marker always means "this clock is bit 0", even mid-packet.
    assign start     = dataIslandActive && !terc4channel0[3];
    assign receiving = (state == STATE_RECEIVING);
    assign capture   = dataIslandActive && (start || receiving);
    assign bit_idx   = start ? 5'd0 : count;
    assign complete  = receiving && dataIslandActive && !start && (count == 5'(PACKET_CLOCKS - 1));
    assign abort     = receiving && (!dataIslandActive || start);
    assign hdr_en    = capture && (bit_idx < 5'(HEADER_DATA_BITS));
    assign sp_en     = capture && (bit_idx < 5'(SUBPACKET_DATA_BITS / 2));

    bch_parity_accumulator #(.BITS_PER_CLOCK(1)) u_hdr_bch (
        .clock  (clock),
        .nReset (nReset),
        .clear  (start),
        .enable (hdr_en),
        .data   (terc4channel0[2]),
        .parity (hdr_par_calc)
    );

    for (genvar i = 0; i < 4; i++) begin : g_sp
        bch_parity_accumulator #(.BITS_PER_CLOCK(2)) u_sp_bch (
            .clock  (clock),
            .nReset (nReset),
            .clear  (start),
            .enable (sp_en),
            .data   ({terc4channel2[i], terc4channel1[i]}),
            .parity (sp_par_calc[i])
        );
    end

    // Received parity fills from the top so the first parity bit lands at bit 0;
    // the final bit arrives on the completion clock and is merged combinationally.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            hdr_data   <= '0;
            sp_data    <= '0;
            hdr_par_rx <= '0;
            sp_par_rx  <= '0;
        end else if (capture && !complete) begin
            if (hdr_en) begin
                hdr_data[bit_idx] <= terc4channel0[2];
            end else begin
                hdr_par_rx <= {terc4channel0[2], hdr_par_rx[6:1]};
            end
            for (int i = 0; i < 4; i++) begin
                if (sp_en) begin
                    sp_data[i][{bit_idx, 1'b0} +: 2] <= {terc4channel2[i], terc4channel1[i]};
                end else begin
                    sp_par_rx[i] <= {terc4channel2[i], terc4channel1[i], sp_par_rx[i][5:2]};
                end
            end
        end
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state         <= STATE_IDLE;
            count         <= '0;
            header        <= '0;
            subpacket0    <= '0;
            subpacket1    <= '0;
            subpacket2    <= '0;
            subpacket3    <= '0;
            eccError      <= '0;
            packetValid   <= 1'b0;
            packetAborted <= 1'b0;
        end else begin
            packetValid   <= complete;
            packetAborted <= abort;
            if (complete) begin
                state      <= STATE_IDLE;
                count      <= '0;
                header     <= hdr_data;
                subpacket0 <= sp_data[0];
                subpacket1 <= sp_data[1];
                subpacket2 <= sp_data[2];
                subpacket3 <= sp_data[3];
                eccError[0] <= hdr_par_calc != {terc4channel0[2], hdr_par_rx};
                for (int i = 0; i < 4; i++) begin
                    eccError[1+i] <= sp_par_calc[i] !=
                                     {terc4channel2[i], terc4channel1[i], sp_par_rx[i]};
                end
            end else if (capture) begin
                state <= STATE_RECEIVING;
                count <= bit_idx + 5'd1;
            end else begin
                state <= STATE_IDLE;
                count <= '0;
            end
        end
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            hsync <= 1'b0;
            vsync <= 1'b0;
        end else if (dataIslandActive) begin
            hsync <= terc4channel0[0];
            vsync <= terc4channel0[1];
        end
    end

endmodule

// File: tb/tb_data_island_packet_deserializer.sv
// Randomized scoreboard bench for the data island packet deserializer.
module tb_data_island_packet_deserializer;

    logic        clock = 1'b0;
    logic        nReset;
    logic        dataIslandActive;
    logic [3:0]  terc4channel0, terc4channel1, terc4channel2;
    logic [23:0] header;
    logic [55:0] subpacket0, subpacket1, subpacket2, subpacket3;
    logic        packetValid, packetAborted, hsync, vsync;
    logic [4:0]  eccError;

    always #5 clock = ~clock;

    data_island_packet_deserializer dut (
        .clock            (clock),
        .nReset           (nReset),
        .dataIslandActive (dataIslandActive),
        .terc4channel0    (terc4channel0),
        .terc4channel1    (terc4channel1),
        .terc4channel2    (terc4channel2),
        .header           (header),
        .subpacket0       (subpacket0),
        .subpacket1       (subpacket1),
        .subpacket2       (subpacket2),
        .subpacket3       (subpacket3),
        .packetValid      (packetValid),
        .eccError         (eccError),
        .packetAborted    (packetAborted),
        .hsync            (hsync),
        .vsync            (vsync)
    );

    typedef struct {
        bit               is_abort;
        logic [23:0]      h;
        logic [3:0][55:0] s;
        logic [4:0]       ecc;
    } exp_t;

    exp_t             exp_q[$];
    int               n_tests = 0;
    int               n_fail  = 0;
    logic [23:0]      held_h   = '0;
    logic [3:0][55:0] held_s   = '0;
    logic [4:0]       held_ecc = '0;
    logic             hs_m = 1'b0;
    logic             vs_m = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Golden BCH: parity of the first n bits of a block, bit 0 first.
    function automatic logic [7:0] golden_bch(input logic [63:0] bits, input int n);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < n; i++) begin
            if (bits[i] ^ p[0]) p = (p >> 1) ^ 8'h83;
            else                p = p >> 1;
        end
        return p;
    endfunction

    task automatic build(input logic [23:0] h, input logic [3:0][55:0] s,
                         output logic [31:0] wh, output logic [3:0][63:0] ws);
        wh = {golden_bch({40'd0, h}, 24), h};
        for (int i = 0; i < 4; i++) ws[i] = {golden_bch({8'd0, s[i]}, 56), s[i]};
    endtask

    // One wire clock k of a packet; bit 3 of channel 0 is the start marker (low only at k=0).
    task automatic drive_clock(input logic [31:0] wh, input logic [3:0][63:0] ws, input int k);
        dataIslandActive = 1'b1;
        terc4channel0 = {(k != 0), wh[k], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
        for (int i = 0; i < 4; i++) begin
            terc4channel1[i] = ws[i][2*k];
            terc4channel2[i] = ws[i][2*k+1];
        end
        @(posedge clock);
        #1;
    endtask

    task automatic gap(input int n);
        for (int c = 0; c < n; c++) begin
            dataIslandActive = 1'($urandom_range(0, 1));
            terc4channel0 = {1'b1, 3'($urandom_range(0, 7))};
            terc4channel1 = 4'($urandom_range(0, 15));
            terc4channel2 = 4'($urandom_range(0, 15));
            @(posedge clock);
            #1;
        end
    endtask

    // mode 0: full packet; 1: drop active at stop_at; 2: new marker at stop_at (caller sends next);
    // 3: reset at stop_at.
    task automatic send(input logic [31:0] wh, input logic [3:0][63:0] ws,
                        input int stop_at, input int mode);
        exp_t e;
        int   nclk;
        nclk = (mode == 0) ? 32 : stop_at;
        if (mode == 0) begin
            e.is_abort = 1'b0;
            e.h        = wh[23:0];
            e.ecc[0]   = golden_bch({40'd0, wh[23:0]}, 24) != wh[31:24];
            for (int i = 0; i < 4; i++) begin
                e.s[i]     = ws[i][55:0];
                e.ecc[1+i] = golden_bch({8'd0, ws[i][55:0]}, 56) != ws[i][63:56];
            end
            exp_q.push_back(e);
        end
        for (int k = 0; k < nclk; k++) drive_clock(wh, ws, k);
        if (mode == 0) begin
            check("valid_latency", packetValid, 1'b1);
        end else if (mode == 1 || mode == 2) begin
            e.is_abort = 1'b1;
            e.h = '0; e.s = '0; e.ecc = '0;
            exp_q.push_back(e);
            if (mode == 1) begin
                dataIslandActive = 1'b0;
                @(posedge clock);
                #1;
                check("abort_pulse", packetAborted, 1'b1);
            end
        end else begin
            dataIslandActive = 1'b0;
            nReset = 1'b0;
            #1;
            check("rst_header", header, '0);
            check("rst_sp0", subpacket0, '0);
            check("rst_sp3", subpacket3, '0);
            check("rst_ecc", eccError, '0);
            check("rst_valid", packetValid, 1'b0);
            check("rst_abort", packetAborted, 1'b0);
            check("rst_sync", {hsync, vsync}, 2'b00);
            held_h = '0; held_s = '0; held_ecc = '0; hs_m = 1'b0; vs_m = 1'b0;
            repeat (2) @(posedge clock);
            @(negedge clock);
            nReset = 1'b1;
            @(posedge clock);
            #1;
        end
    endtask

    always @(posedge clock) begin
        if (nReset && dataIslandActive) begin
            hs_m = terc4channel0[0];
            vs_m = terc4channel0[1];
        end
    end

    // Monitor: pops an expectation whenever the DUT reports a packet event.
    always @(negedge clock) begin
        exp_t e;
        if (nReset) begin
            check("hsync", hsync, hs_m);
            check("vsync", vsync, vs_m);
            if (packetValid && packetAborted) check("valid_and_abort", 2'b11, 2'b01);
            if (packetValid || packetAborted) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_event: valid=%b aborted=%b with empty queue",
                             packetValid, packetAborted);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind", packetAborted, e.is_abort);
                    if (!e.is_abort) begin
                        held_h = e.h; held_s = e.s; held_ecc = e.ecc;
                    end
                    check("header", header, held_h);
                    check("subpacket0", subpacket0, held_s[0]);
                    check("subpacket1", subpacket1, held_s[1]);
                    check("subpacket2", subpacket2, held_s[2]);
                    check("subpacket3", subpacket3, held_s[3]);
                    check("eccError", eccError, held_ecc);
                end
            end
        end
    end

    initial begin
        logic [31:0]      wh, wh2;
        logic [3:0][63:0] ws, ws2;
        logic [3:0][55:0] s;
        int               fb, wait_cnt;

        nReset = 1'b0;
        dataIslandActive = 1'b0;
        terc4channel0 = 4'hF; terc4channel1 = '0; terc4channel2 = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_header", header, '0);
        check("reset_sp", {subpacket0, subpacket1[7:0]}, '0);
        check("reset_ecc", eccError, '0);
        check("reset_valid", packetValid, 1'b0);
        check("reset_abort", packetAborted, 1'b0);
        check("reset_sync", {hsync, vsync}, 2'b00);
        @(negedge clock);
        nReset = 1'b1;
        @(posedge clock);
        #1;

        s = '0;
        build(24'h0, s, wh, ws);
        send(wh, ws, -1, 0);
        gap(2);

        s[0] = 56'h00000000000A11;
        build(24'h000184, s, wh, ws);
        send(wh, ws, -1, 0);
        gap(1);
        send(wh ^ 32'h20, ws, -1, 0);
        ws2 = ws;
        ws2[2][56+3] = ~ws2[2][56+3];
        send(wh, ws2, -1, 0);
        gap(3);

        for (int n = 0; n < 14; n++) begin
            for (int i = 0; i < 4; i++) s[i] = {24'($urandom), $urandom};
            build(24'($urandom), s, wh, ws);
            if ($urandom_range(0, 2) == 0) begin
                fb = $urandom_range(0, 32 + 4*64 - 1);
                if (fb < 32) wh[fb] = ~wh[fb];
                else ws[(fb-32)/64][(fb-32)%64] = ~ws[(fb-32)/64][(fb-32)%64];
            end
            send(wh, ws, -1, 0);
            gap($urandom_range(0, 3));
        end

        for (int i = 0; i < 4; i++) s[i] = {24'($urandom), $urandom};
        build(24'($urandom), s, wh, ws);
        send(wh, ws, 10, 1);
        gap(2);

        build(24'($urandom), s, wh, ws);
        for (int i = 0; i < 4; i++) s[i] = {24'($urandom), $urandom};
        build(24'($urandom), s, wh2, ws2);
        send(wh, ws, 20, 2);
        send(wh2, ws2, -1, 0);
        gap(2);

        send(wh, ws, 15, 3);
        gap(1);
        send(wh2, ws2, -1, 0);
        gap(2);

        wait_cnt = 0;
        while (exp_q.size() != 0 && wait_cnt < 100) begin
            @(posedge clock);
            wait_cnt++;
        end
        check("queue_drained", exp_q.size(), 0);
        @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
